// File: rtl/sat_engine_loader_if.sv
// ---------------------------------------------------------------------------
// sat_engine_loader_if
//
// Purpose : bundles the two streaming handshakes that sit between the bin
//           manager and sat_engine_loader.
//           - clause-in stream : bin manager -> loader, one clause per beat
//           - read-back stream : loader -> bin manager, one clause per beat
//
// Signal names keep the loader's point of view (_i = into the loader,
// _o = out of the loader) so they read the same inside the loader and in
// the bin manager.
//
// Modports:
//   master : bin-manager side (drives clause-in, consumes read-back)
//   slave  : loader side      (consumes clause-in, drives read-back)
// ---------------------------------------------------------------------------
interface sat_engine_loader_if #(
    parameter int NUM_VARS = 8
) ();

    logic                  cls_valid_i;
    logic                  cls_ready_o;
    logic [2*NUM_VARS-1:0] cls_data_i;

    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [2*NUM_VARS-1:0] wb_data_o;

    modport master (
        output cls_valid_i,
        output cls_data_i,
        input  cls_ready_o,
        input  wb_valid_o,
        input  wb_data_o,
        output wb_ready_i
    );

    modport slave (
        input  cls_valid_i,
        input  cls_data_i,
        output cls_ready_o,
        output wb_valid_o,
        output wb_data_o,
        input  wb_ready_i
    );

endinterface

// File: rtl/sat_engine_loader.sv
// ---------------------------------------------------------------------------
// sat_engine_loader
//
// Purpose : upstream sequencer for sat_engine. Accepts one bin, streams its
//           clauses into the engine clause array one row per cycle, writes the
//           variable and level state vectors, starts the engine, waits for it
//           to finish and (optionally) reads the clause array back out.
//           The loader owns every engine strobe, so load, run and read-back
//           phases never overlap.
//
// Build option:
//   LOADER_WB_EN  defined     -> clause read-back phase (WB_CLS) present.
//                 not defined -> RUN goes straight to DONE; rd_carray_o,
//                                wb_valid_o and wb_data_o are tied to zero.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   bus                 clause-in / read-back handshakes (slave modport)
//   start_load_i        one-cycle load request, honoured only in IDLE
//   cur_bin_num_i,
//   load_lvl_i,
//   base_lvl_i          bin parameters, captured on the accepted request
//   vars_states_i       variable-state vector, captured on the request
//   lvl_states_i        level-state vector, captured on the request
//   wr_carray_o         one-hot clause-row write strobe
//   rd_carray_o         one-hot clause-row read strobe
//   clause_o            clause-row write data
//   clause_core_i       clause-row read data from the engine
//   wr_var_states_o     variable-state write strobes
//   vars_states_o       variable-state write data
//   wr_lvl_states_o     level-state write strobes
//   lvl_states_o        level-state write data
//   start_core_o        one-cycle engine start pulse
//   base_lvl_en_o       base-level write enable (with start_core_o)
//   cur_bin_num_o,
//   load_lvl_o,
//   base_lvl_o          captured parameters presented to the engine
//   done_core_i         engine completion, only honoured in RUN
//   busy_o              high in every state but IDLE
//   done_o              one-cycle completion pulse
// ---------------------------------------------------------------------------
module sat_engine_loader #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,

    sat_engine_loader_if.slave                   bus,

    input  logic                                 start_load_i,
    input  logic [WIDTH_LVL-1:0]                 cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,

    output logic [NUM_CLAUSES-1:0]               wr_carray_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    output logic [2*NUM_VARS-1:0]                clause_o,
    input  logic [2*NUM_VARS-1:0]                clause_core_i,

    output logic [NUM_VARS-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,

    output logic                                 start_core_o,
    output logic                                 base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 load_lvl_o,
    output logic [WIDTH_LVL-1:0]                 base_lvl_o,
    input  logic                                 done_core_i,

    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int CLS_W = 2 * NUM_VARS;
    localparam int VS_W  = WIDTH_VAR_STATES * NUM_VARS;
    localparam int LS_W  = WIDTH_LVL_STATES * NUM_LVLS;
    // Row counter is at least one bit wide so a single-row array still works.
    localparam int CW    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_CLAUSES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_CLS = 3'd1,
        LD_VS  = 3'd2,
        LD_LS  = 3'd3,
        START  = 3'd4,
        RUN    = 3'd5,
        WB_CLS = 3'd6,
        DONE   = 3'd7
    } state_e;

    // One-hot strobe for a clause row.
    function automatic logic [NUM_CLAUSES-1:0] row_strobe(input logic [CW-1:0] row);
        row_strobe = NUM_CLAUSES'(1'b1) << row;
    endfunction

    state_e                  state_q;
    logic [CW-1:0]           row_q;
    logic                    cls_ready_q;
    logic [NUM_CLAUSES-1:0]  wr_carray_q;
    logic [CLS_W-1:0]        clause_q;
    logic [NUM_VARS-1:0]     wr_var_q;
    logic [NUM_LVLS-1:0]     wr_lvl_q;
    logic [VS_W-1:0]         vars_states_q;
    logic [LS_W-1:0]         lvl_states_q;
    logic                    start_core_q;
    logic                    base_lvl_en_q;
    logic [WIDTH_LVL-1:0]    cur_bin_num_q;
    logic [WIDTH_LVL-1:0]    load_lvl_q;
    logic [WIDTH_LVL-1:0]    base_lvl_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    cls_accept_s;

`ifdef LOADER_WB_EN
    logic [NUM_CLAUSES-1:0]  rd_carray_q;
    logic                    rd_pend_q;   // read strobe is on the bus this cycle
    logic                    wb_valid_q;
    logic [CLS_W-1:0]        wb_data_q;
`endif

    // A clause beat is taken only while the registered ready is high.
    assign cls_accept_s = bus.cls_valid_i & cls_ready_q;

    // Sequencer FSM: state, row counter, captured bin and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            row_q         <= '0;
            cls_ready_q   <= 1'b0;
            wr_carray_q   <= '0;
            clause_q      <= '0;
            wr_var_q      <= '0;
            wr_lvl_q      <= '0;
            vars_states_q <= '0;
            lvl_states_q  <= '0;
            start_core_q  <= 1'b0;
            base_lvl_en_q <= 1'b0;
            cur_bin_num_q <= '0;
            load_lvl_q    <= '0;
            base_lvl_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef LOADER_WB_EN
            rd_carray_q   <= '0;
            rd_pend_q     <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
`endif
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            wr_carray_q   <= '0;
            wr_var_q      <= '0;
            wr_lvl_q      <= '0;
            start_core_q  <= 1'b0;
            base_lvl_en_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef LOADER_WB_EN
            rd_carray_q   <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (start_load_i) begin
                        cur_bin_num_q <= cur_bin_num_i;
                        load_lvl_q    <= load_lvl_i;
                        base_lvl_q    <= base_lvl_i;
                        vars_states_q <= vars_states_i;
                        lvl_states_q  <= lvl_states_i;
                        row_q         <= '0;
                        cls_ready_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= LD_CLS;
                    end
                end

                LD_CLS: begin
                    if (cls_accept_s) begin
                        wr_carray_q <= row_strobe(row_q);
                        clause_q    <= bus.cls_data_i;
                        // Ready drops together with the last write so no
                        // extra beat can slip in.
                        if (row_q == LAST_ROW) begin
                            cls_ready_q <= 1'b0;
                            state_q     <= LD_VS;
                        end else begin
                            row_q <= row_q + CW'(1'b1);
                        end
                    end
                end

                LD_VS: begin
                    wr_var_q <= '1;
                    state_q  <= LD_LS;
                end

                LD_LS: begin
                    wr_lvl_q <= '1;
                    state_q  <= START;
                end

                START: begin
                    start_core_q  <= 1'b1;
                    base_lvl_en_q <= 1'b1;
                    state_q       <= RUN;
                end

                RUN: begin
                    if (done_core_i) begin
`ifdef LOADER_WB_EN
                        row_q      <= '0;
                        rd_pend_q  <= 1'b0;
                        wb_valid_q <= 1'b0;
                        state_q    <= WB_CLS;
`else
                        state_q    <= DONE;
`endif
                    end
                end

`ifdef LOADER_WB_EN
                // Three-phase row loop: issue strobe, capture engine data,
                // hold until the bin manager takes it. The next strobe is
                // issued in the handshake cycle, so one row costs 2 cycles
                // when wb_ready_i is high.
                WB_CLS: begin
                    if (rd_pend_q) begin
                        wb_data_q  <= clause_core_i;
                        wb_valid_q <= 1'b1;
                        rd_pend_q  <= 1'b0;
                    end else if (wb_valid_q) begin
                        if (bus.wb_ready_i) begin
                            wb_valid_q <= 1'b0;
                            if (row_q == LAST_ROW) begin
                                state_q <= DONE;
                            end else begin
                                row_q       <= row_q + CW'(1'b1);
                                rd_carray_q <= row_strobe(row_q + CW'(1'b1));
                                rd_pend_q   <= 1'b1;
                            end
                        end
                    end else begin
                        rd_carray_q <= row_strobe(row_q);
                        rd_pend_q   <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    cls_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.cls_ready_o = cls_ready_q;
    assign wr_carray_o     = wr_carray_q;
    assign clause_o        = clause_q;
    assign wr_var_states_o = wr_var_q;
    assign vars_states_o   = vars_states_q;
    assign wr_lvl_states_o = wr_lvl_q;
    assign lvl_states_o    = lvl_states_q;
    assign start_core_o    = start_core_q;
    assign base_lvl_en_o   = base_lvl_en_q;
    assign cur_bin_num_o   = cur_bin_num_q;
    assign load_lvl_o      = load_lvl_q;
    assign base_lvl_o      = base_lvl_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

`ifdef LOADER_WB_EN
    assign rd_carray_o     = rd_carray_q;
    assign bus.wb_valid_o  = wb_valid_q;
    assign bus.wb_data_o   = wb_data_q;
`else
    logic unused_wb_s;

    assign rd_carray_o     = '0;
    assign bus.wb_valid_o  = 1'b0;
    assign bus.wb_data_o   = '0;
    // Read-back inputs have no consumer without the read-back phase.
    assign unused_wb_s     = ^{bus.wb_ready_i, clause_core_i};
`endif

endmodule
